// File: rtl/line_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : line_packer_if
//  Purpose  : Pixel-stream and line-FIFO write signals for line_packer.
//             master = stream source / FIFO side, slave = the packer.
//  Revision : 1.0  initial release
// ============================================================================
interface line_packer_if #(
    parameter int PIX_PER_WORD = 16
);
    logic [7:0]                  pix_data;
    logic                        pix_valid;
    logic                        line_start;
    logic                        wrfull;
    logic [8*PIX_PER_WORD-1:0]   wrdata;
    logic                        wrfifo;
    logic                        line_done;
    logic [1:0]                  stateoutput;

    modport master (
        output pix_data, pix_valid, line_start, wrfull,
        input  wrdata, wrfifo, line_done, stateoutput
    );

    modport slave (
        input  pix_data, pix_valid, line_start, wrfull,
        output wrdata, wrfifo, line_done, stateoutput
    );
endinterface
`default_nettype wire

// File: rtl/line_packer.sv
`default_nettype none
// ============================================================================
//  Module   : line_packer
//  Purpose  : Packs 8-bit pixels into 128-bit words, exactly PERIOD_NUM words
//             per line (short/overflowed lines zero padded), written to the
//             line FIFO through a 2-entry output buffer.
//  Option   : LINE_PACKER_STATS_EN adds the drop_count output.
//  Revision : 1.0  initial release
// ============================================================================
module line_packer #(
    parameter int PERIOD_NUM   = 21,
    parameter int PIX_PER_WORD = 16
) (
    input  wire             clk,
    input  wire             reset,
    input  wire             ce,
    line_packer_if.slave    bus
`ifdef LINE_PACKER_STATS_EN
    ,
    output logic [15:0]     drop_count
`endif
);

    localparam int c_WORD_W  = 8 * PIX_PER_WORD;
    localparam int c_BYTE_IW = $clog2(PIX_PER_WORD);
    localparam int c_WORD_IW = $clog2(PERIOD_NUM + 1);
    localparam logic [c_BYTE_IW-1:0] c_BYTE_LAST = c_BYTE_IW'(PIX_PER_WORD - 1);
    localparam logic [c_WORD_IW-1:0] c_WORD_LAST = c_WORD_IW'(PERIOD_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_BYTE_IW-1:0]   r_byte_idx;
    logic [c_WORD_IW-1:0]   r_word_idx;
    logic [c_WORD_W-1:0]    r_acc;
    logic [c_WORD_W-1:0]    r_buf [2];
    logic                   r_last [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    logic                   w_pop;
    logic                   w_space;
    logic                   w_accept;
    logic                   w_byte_last;
    logic                   w_word_last;
    logic                   w_push;
    logic                   w_push_last;
    logic [c_WORD_W-1:0]    w_push_data;

    // A pop frees a slot in the same cycle, so a full buffer still accepts a push
    assign w_pop       = ce && (r_count != 2'd0) && !bus.wrfull;
    assign w_space     = (r_count != 2'd2) || w_pop;
    assign w_accept    = ce && bus.pix_valid;
    assign w_byte_last = (r_byte_idx == c_BYTE_LAST);
    assign w_word_last = (r_word_idx == c_WORD_LAST);

    assign bus.wrfifo      = w_pop;
    assign bus.wrdata      = r_buf[r_rd_ptr];
    assign bus.line_done   = w_pop && r_last[r_rd_ptr];
    assign bus.stateoutput = r_state;

    // Select the word (if any) entering the output buffer this cycle
    always_comb begin
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_push_data = '0;
        if (ce) begin
            case (r_state)
                S_PACK: begin
                    if (bus.line_start) begin
                        // Flush the partial word; unfilled bytes are already zero
                        if (r_byte_idx != '0 && w_space) begin
                            w_push      = 1'b1;
                            w_push_data = r_acc;
                            w_push_last = w_word_last;
                        end
                    end else if (w_accept && w_byte_last && w_space) begin
                        w_push      = 1'b1;
                        w_push_data = {bus.pix_data, r_acc[c_WORD_W-9:0]};
                        w_push_last = w_word_last;
                    end
                end
                S_PAD: begin
                    if (w_space) begin
                        w_push      = 1'b1;
                        w_push_last = w_word_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output buffer, packing counters and line FSM; ce low freezes everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_acc      <= '0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_last[0]  <= 1'b0;
            r_last[1]  <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else if (ce) begin
            if (w_push) begin
                r_buf[r_wr_ptr]  <= w_push_data;
                r_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr         <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (bus.line_start) begin
                        r_state    <= S_PACK;
                        r_word_idx <= '0;
                        if (bus.pix_valid) begin
                            r_acc      <= {{(c_WORD_W-8){1'b0}}, bus.pix_data};
                            r_byte_idx <= c_BYTE_IW'(1);
                        end else begin
                            r_acc      <= '0;
                            r_byte_idx <= '0;
                        end
                    end
                end
                S_PACK: begin
                    if (bus.line_start) begin
                        // Early line start: pad out this line, lose the new one
                        r_byte_idx <= '0;
                        r_acc      <= '0;
                        if (w_push && w_word_last) begin
                            r_state    <= S_IDLE;
                            r_word_idx <= '0;
                        end else begin
                            r_state <= S_PAD;
                            if (w_push) begin
                                r_word_idx <= r_word_idx + 1'b1;
                            end
                        end
                    end else if (w_accept) begin
                        if (w_byte_last) begin
                            r_byte_idx <= '0;
                            r_acc      <= '0;
                            if (!w_push) begin
                                // Buffer full: this word and the rest of the line become zeros
                                r_state <= S_PAD;
                            end else if (w_word_last) begin
                                r_state    <= S_IDLE;
                                r_word_idx <= '0;
                            end else begin
                                r_word_idx <= r_word_idx + 1'b1;
                            end
                        end else begin
                            r_acc[{r_byte_idx, 3'b000} +: 8] <= bus.pix_data;
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (w_push) begin
                        if (w_word_last) begin
                            r_state    <= S_IDLE;
                            r_word_idx <= '0;
                        end else begin
                            r_word_idx <= r_word_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LINE_PACKER_STATS_EN
    logic w_enter_pad;

    assign w_enter_pad = ce && (r_state == S_PACK) &&
                         (bus.line_start ? !(w_push && w_word_last)
                                         : (w_accept && w_byte_last && !w_push));

    // Count lines that fall back to zero padding, saturating at all ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (w_enter_pad && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
